store_circuit: RTL and testbench

STORE_CIRCUIT -- requirements
Module: store_circuit

---
 rtl/store_circuit.sv | 142 ++++++++++++++
 tb/tb_store_circuit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/store_circuit.sv
// STA (store accumulator) sequencer: latches IR/AC on start, decodes,
// optionally fetches an indirect pointer, then issues one memory write.
//
// Ports:
//   clk, reset_n (async active-low)  : clock and reset
//   start, clr                       : request (IDLE only) / synchronous abort
//   ir_data, ac_data                 : instruction and value to store
//   mem_rdata                        : combinational read data for mem_addr
//   mem_addr, mem_wdata              : memory address (=AR) / write data (=AC)
//   mem_re, mem_we                   : read / write strobes
//   s, ar_data                       : T-state encoding / address register
//   busy, done, err                  : status, completion and illegal-op pulses
module store_circuit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        clr,
  input  logic [15:0] ir_data,
  input  logic [15:0] ac_data,
  input  logic [15:0] mem_rdata,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [2:0]  s,
  output logic [11:0] ar_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd2,
    S_IND    = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  localparam logic [2:0] OP_STA = 3'b011;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ac_q, ac_d;
  logic [11:0] ar_q, ar_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        is_sta;
  logic        accept;

  assign is_sta = (ir_q[14:12] == OP_STA);
  assign accept = (state_q == S_IDLE) && start && !clr;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clr overrides every transition
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_DECODE;
        end
        S_DECODE: begin
          if (!is_sta)
            state_d = S_IDLE;
          else if (ir_q[15])
            state_d = S_IND;
          else
            state_d = S_WRITE;
        end
        S_IND:   state_d = S_WRITE;
        S_WRITE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs; strobes are gated by clr so an abort never touches memory
  always_comb begin
    mem_re    = (state_q == S_IND) && !clr;
    mem_we    = (state_q == S_WRITE) && !clr;
    mem_addr  = ar_q;
    mem_wdata = ac_q;
    s         = state_q;
    ar_data   = ar_q;
    busy      = (state_q != S_IDLE);
    done      = done_q;
    err       = err_q;
  end

  // Datapath next-state
  always_comb begin
    ir_d   = ir_q;
    ac_d   = ac_q;
    ar_d   = ar_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    if (accept) begin
      ir_d = ir_data;
      ac_d = ac_data;
    end
    if (!clr) begin
      unique case (state_q)
        S_DECODE: begin
          ar_d  = ir_q[11:0];
          err_d = !is_sta;
        end
        // Pointer is 12 bits; upper data bits are ignored
        S_IND:   ar_d   = mem_rdata[11:0];
        S_WRITE: done_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q   <= '0;
      ac_q   <= '0;
      ar_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      ac_q   <= ac_d;
      ar_q   <= ar_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_store_circuit.sv
// Directed bench for store_circuit: direct/indirect STA, illegal op,
// clr abort, async reset mid-operation and back-to-back starts.
module tb_store_circuit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        clr;
  logic [15:0] ir_data;
  logic [15:0] ac_data;
  logic [15:0] mem_rdata;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [2:0]  s;
  logic [11:0] ar_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  store_circuit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .clr       (clr),
    .ir_data   (ir_data),
    .ac_data   (ac_data),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .s         (s),
    .ar_data   (ar_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small memory image for pointer fetches
  always_comb begin
    mem_rdata = 16'h0000;
    if (mem_addr == 12'h040) mem_rdata = 16'h0ABC;
    if (mem_addr == 12'h041) mem_rdata = 16'hF055;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    clr     = 1'b0;
    ir_data = 16'h0;
    ac_data = 16'h0;
    #12;
    chk("rst_s", s, 0);
    chk("rst_ar", ar_data, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_re, mem_we, done, err}, 0);

    // Direct STA, accepted on the first edge after reset release
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b1;
    ir_data = 16'h3123;
    ac_data = 16'hBEEF;
    settle();
    chk("d_idle_s", s, 0);
    tick();
    start = 1'b0; ir_data = 16'h0; ac_data = 16'h0;
    settle();
    chk("d_dec_s", s, 2);
    chk("d_dec_busy", busy, 1);
    chk("d_dec_strb", {mem_re, mem_we}, 0);
    tick(); settle();
    chk("d_wr_s", s, 4);
    chk("d_wr_strb", {mem_re, mem_we}, 2'b01);
    chk("d_wr_addr", mem_addr, 12'h123);
    chk("d_wr_data", mem_wdata, 16'hBEEF);
    tick(); settle();
    chk("d_done_s", s, 0);
    chk("d_done", {done, err, mem_we}, 3'b100);
    tick(); settle();
    chk("d_done_off", done, 0);

    // Indirect STA through mem[040]
    start = 1'b1; ir_data = 16'hB040; ac_data = 16'h1234;
    tick();
    start = 1'b0; ac_data = 16'h9999;
    settle();
    chk("i_dec_s", s, 2);
    tick(); settle();
    chk("i_ind_s", s, 3);
    chk("i_ind_strb", {mem_re, mem_we}, 2'b10);
    chk("i_ind_addr", mem_addr, 12'h040);
    tick(); settle();
    chk("i_wr_s", s, 4);
    chk("i_wr_strb", {mem_re, mem_we}, 2'b01);
    chk("i_wr_addr", mem_addr, 12'hABC);
    chk("i_wr_data", mem_wdata, 16'h1234);
    tick(); settle();
    chk("i_done", {s, done}, {3'd0, 1'b1});

    // Illegal opcode
    start = 1'b1; ir_data = 16'h7001;
    tick();
    start = 1'b0;
    settle();
    chk("e_dec_s", s, 2);
    chk("e_dec_strb", {mem_re, mem_we}, 0);
    tick(); settle();
    chk("e_idle_s", s, 0);
    chk("e_pulse", {err, done, mem_re, mem_we}, 4'b1000);
    tick(); settle();
    chk("e_off", err, 0);

    // clr during WRITE
    start = 1'b1; ir_data = 16'h3123; ac_data = 16'h5555;
    tick();
    start = 1'b0;
    tick();
    clr = 1'b1;
    settle();
    chk("c_wr_s", s, 4);
    chk("c_we_gated", mem_we, 0);
    tick();
    clr = 1'b0;
    settle();
    chk("c_idle", {s, busy, done}, 0);
    tick(); settle();
    chk("c_nodone", done, 0);

    // clr beats start in IDLE
    start = 1'b1; clr = 1'b1;
    tick();
    start = 1'b0; clr = 1'b0;
    settle();
    chk("c_win", s, 0);

    // Async reset during INDIRECT
    start = 1'b1; ir_data = 16'hB040; ac_data = 16'h1111;
    tick();
    start = 1'b0;
    tick(); settle();
    chk("r_ind_re", mem_re, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("r_async_s", s, 0);
    chk("r_async_ar", ar_data, 0);
    chk("r_async_o", {mem_re, mem_we, busy, done, err}, 0);
    chk("r_async_wd", mem_wdata, 0);
    #1;
    reset_n = 1'b1;
    start = 1'b1; ir_data = 16'h3200; ac_data = 16'h7777;
    tick();
    start = 1'b0;
    tick(); settle();
    chk("r_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 12'h200, 16'h7777});
    tick(); settle();
    chk("r_done", done, 1);

    // Back-to-back: start held through the done cycle
    start = 1'b1; ir_data = 16'h3010; ac_data = 16'hAAAA;
    tick();
    ir_data = 16'hB041; ac_data = 16'hBBBB;
    settle();
    chk("b_dec_s", s, 2);
    tick(); settle();
    chk("b_wr_s", s, 4);
    chk("b_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 12'h010, 16'hAAAA});
    tick(); settle();
    chk("b_done", {s, done}, {3'd0, 1'b1});
    tick();
    start = 1'b0; ac_data = 16'hCCCC;
    settle();
    chk("b2_dec_s", s, 2);
    tick(); settle();
    chk("b2_ind", {s, mem_re, mem_addr}, {3'd3, 1'b1, 12'h041});
    tick(); settle();
    chk("b2_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 12'h055, 16'hBBBB});
    tick(); settle();
    chk("b2_done", {s, done}, {3'd0, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
